// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared widths and state encoding for the accumulator feeder
package acc_pkg;

    localparam int IN_DATA_WIDTH = 8;
    localparam int DWIDTH        = 16;
    localparam int AWIDTH        = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/acc_feeder_if.sv
// rtl/acc_feeder_if.sv - operand memory and accumulator bus between feeder and core
interface acc_feeder_if
    import acc_pkg::*;
#(
    parameter int IN_W = IN_DATA_WIDTH,
    parameter int D_W  = DWIDTH,
    parameter int A_W  = AWIDTH
);
    logic [A_W-1:0]  addr_o;
    logic            ce_o;
    logic [IN_W-1:0] q_i;
    logic            run_o;
    logic            valid_o;
    logic [IN_W-1:0] number_o;
    logic            acc_valid_i;
    logic [D_W-1:0]  acc_result_i;

    modport master (
        output addr_o, ce_o, run_o, valid_o, number_o,
        input  q_i, acc_valid_i, acc_result_i
    );

    modport slave (
        input  addr_o, ce_o, run_o, valid_o, number_o,
        output q_i, acc_valid_i, acc_result_i
    );
endinterface

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - clears the accumulator, streams N operands from memory, captures the sum
module acc_feeder
    import acc_pkg::*;
#(
    parameter int IN_W = IN_DATA_WIDTH,
    parameter int D_W  = DWIDTH,
    parameter int A_W  = AWIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [A_W:0]    num_cnt_i,
    acc_feeder_if.master    bus,
    output logic            idle_o,
    output logic            running_o,
    output logic            done_o,
    output logic [D_W-1:0]  result_o
);

    state_t          state;
    logic [A_W:0]    n_r;
    logic [A_W:0]    rd_cnt;
    logic [A_W:0]    rx_cnt;
    logic            valid_r;
    logic [D_W-1:0]  result_r;
    logic [A_W:0]    n_last;

    assign n_last = n_r - (A_W+1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            n_r      <= '0;
            rd_cnt   <= '0;
            rx_cnt   <= '0;
            valid_r  <= 1'b0;
            result_r <= '0;
        end else begin
            // valid trails the read enable by the memory's one-cycle latency
            valid_r <= (state == S_READ);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        n_r    <= num_cnt_i;
                        rd_cnt <= '0;
                        rx_cnt <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (n_r == '0) begin
                        result_r <= '0;
                        state    <= S_DONE;
                    end else begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    // result pulses can already arrive while reads are still issuing
                    if (bus.acc_valid_i) rx_cnt <= rx_cnt + (A_W+1)'(1);
                    if (rd_cnt == n_last) begin
                        state <= S_WAIT;
                    end else begin
                        rd_cnt <= rd_cnt + (A_W+1)'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.acc_valid_i) begin
                        if (rx_cnt == n_last) begin
                            result_r <= bus.acc_result_i;
                            state    <= S_DONE;
                        end else begin
                            rx_cnt <= rx_cnt + (A_W+1)'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.addr_o   = rd_cnt[A_W-1:0];
    assign bus.ce_o     = (state == S_READ);
    assign bus.run_o    = (state == S_RUN);
    assign bus.valid_o  = valid_r;
    assign bus.number_o = bus.q_i;

    assign idle_o    = (state == S_IDLE);
    assign running_o = (state == S_RUN) || (state == S_READ) || (state == S_WAIT);
    assign done_o    = (state == S_DONE);
    assign result_o  = result_r;

endmodule

// File: tb/tb_acc_feeder.sv
// tb/tb_acc_feeder.sv - directed bench for acc_feeder with memory and accumulator models
module tb_acc_feeder;
    import acc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [8:0]  num_cnt_i = '0;
    logic        idle_o, running_o, done_o;
    logic [15:0] result_o;

    acc_feeder_if bus ();

    acc_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .num_cnt_i (num_cnt_i),
        .bus       (bus),
        .idle_o    (idle_o),
        .running_o (running_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  mem_q;
    logic [15:0] acc_sum;
    logic        acc_v;

    always @(posedge clk) if (bus.ce_o) mem_q <= mem[bus.addr_o];

    always @(posedge clk) begin
        if (reset) begin
            acc_sum <= '0;
            acc_v   <= 1'b0;
        end else begin
            acc_v <= bus.valid_o;
            if (bus.run_o) acc_sum <= '0;
            else if (bus.valid_o) acc_sum <= acc_sum + {8'd0, bus.number_o};
        end
    end

    assign bus.q_i          = mem_q;
    assign bus.acc_valid_i  = acc_v;
    assign bus.acc_result_i = acc_sum;

    int errors = 0;
    int checks = 0;

    int m_run_cyc, m_run_cnt, m_vfirst, m_vlast, m_vcnt, m_done_cyc, m_done_cnt;
    int m_ce_cnt, m_addr_bad, m_last_addr, m_overlap, m_running_cnt, m_gap;
    logic [15:0] m_result;
    logic        m_idle_after;

    // Entered at a negedge; cycle 0 is the cycle in which start_i is presented.
    task automatic run_op(input int n, input int limit, input int inj_cyc);
        int exp_addr;
        m_run_cyc = -1; m_run_cnt = 0; m_vfirst = -1; m_vlast = -1; m_vcnt = 0;
        m_done_cyc = -1; m_done_cnt = 0; m_ce_cnt = 0; m_addr_bad = 0; m_last_addr = -1;
        m_overlap = 0; m_running_cnt = 0; m_gap = 0; m_result = 'x; m_idle_after = 1'b0;
        exp_addr = 0;
        num_cnt_i = n[8:0];
        start_i = 1'b1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (bus.run_o) begin
                m_run_cnt++;
                if (m_run_cyc < 0) m_run_cyc = cyc;
            end
            if (bus.valid_o) begin
                if (m_vlast >= 0 && m_vlast != cyc - 1) m_gap++;
                if (m_vfirst < 0) m_vfirst = cyc;
                m_vlast = cyc;
                m_vcnt++;
            end
            if (bus.ce_o) begin
                if (bus.addr_o !== exp_addr[7:0]) m_addr_bad++;
                m_last_addr = int'(bus.addr_o);
                exp_addr++;
                m_ce_cnt++;
            end
            if (bus.run_o && bus.valid_o) m_overlap++;
            if (running_o) m_running_cnt++;
            if (done_o) begin
                m_done_cnt++;
                if (m_done_cyc < 0) begin
                    m_done_cyc = cyc;
                    m_result = result_o;
                end
            end
            start_i = (cyc == inj_cyc);
            if (inj_cyc == cyc) num_cnt_i = 9'd3;
            if (m_done_cyc >= 0 && cyc == m_done_cyc + 1) begin
                m_idle_after = idle_o;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle_o); end
        checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (result_o !== 16'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result_o); end
        checks++; if (bus.ce_o !== 1'b0 || bus.run_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_bus ce=%b run=%b valid=%b exp=0", bus.ce_o, bus.run_o, bus.valid_o);
        end
        checks++; if (bus.addr_o !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.addr_o); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_n4();
        for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
        run_op(4, 40, -1);
        checks++; if (m_run_cyc != 1 || m_run_cnt != 1) begin errors++; $display("FAIL n4_run cyc=%0d cnt=%0d exp cyc=1 cnt=1", m_run_cyc, m_run_cnt); end
        checks++; if (m_vfirst != 3 || m_vlast != 6 || m_vcnt != 4) begin
            errors++; $display("FAIL n4_valid first=%0d last=%0d cnt=%0d exp 3 6 4", m_vfirst, m_vlast, m_vcnt);
        end
        checks++; if (m_done_cyc != 8 || m_done_cnt != 1) begin errors++; $display("FAIL n4_done cyc=%0d cnt=%0d exp cyc=8 cnt=1", m_done_cyc, m_done_cnt); end
        checks++; if (m_result !== 16'd10) begin errors++; $display("FAIL n4_result got=%0d exp=10", m_result); end
        checks++; if (m_running_cnt != 7) begin errors++; $display("FAIL n4_running got=%0d exp=7", m_running_cnt); end
        checks++; if (m_overlap != 0 || m_gap != 0) begin errors++; $display("FAIL n4_overlap overlap=%0d gap=%0d exp 0 0", m_overlap, m_gap); end
        checks++; if (m_idle_after !== 1'b1) begin errors++; $display("FAIL n4_idle_after got=%b exp=1", m_idle_after); end
    endtask

    task automatic test_n256();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        run_op(256, 400, -1);
        checks++; if (m_ce_cnt != 256 || m_addr_bad != 0) begin errors++; $display("FAIL n256_addr ce=%0d bad=%0d exp 256 0", m_ce_cnt, m_addr_bad); end
        checks++; if (m_last_addr != 255) begin errors++; $display("FAIL n256_last_addr got=%0d exp=255", m_last_addr); end
        checks++; if (m_vcnt != 256 || m_gap != 0) begin errors++; $display("FAIL n256_valid cnt=%0d gap=%0d exp 256 0", m_vcnt, m_gap); end
        checks++; if (m_done_cyc != 260) begin errors++; $display("FAIL n256_done got=%0d exp=260", m_done_cyc); end
        checks++; if (m_result !== 16'd65280) begin errors++; $display("FAIL n256_result got=%0d exp=65280", m_result); end
    endtask

    task automatic test_n0();
        run_op(0, 20, -1);
        checks++; if (m_run_cyc != 1) begin errors++; $display("FAIL n0_run got=%0d exp=1", m_run_cyc); end
        checks++; if (m_done_cyc != 2) begin errors++; $display("FAIL n0_done got=%0d exp=2", m_done_cyc); end
        checks++; if (m_result !== 16'd0) begin errors++; $display("FAIL n0_result got=%0d exp=0", m_result); end
        checks++; if (m_ce_cnt != 0 || m_vcnt != 0) begin errors++; $display("FAIL n0_ce ce=%0d valid=%0d exp 0 0", m_ce_cnt, m_vcnt); end
    endtask

    task automatic test_back_to_back();
        mem[0] = 8'd5; mem[1] = 8'd6;
        run_op(2, 30, -1);
        checks++; if (m_result !== 16'd11 || m_done_cyc != 6) begin errors++; $display("FAIL b2b_first result=%0d done=%0d exp 11 6", m_result, m_done_cyc); end
        checks++; if (m_idle_after !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", m_idle_after); end
        mem[0] = 8'd7;
        run_op(1, 30, -1);
        checks++; if (m_result !== 16'd7 || m_done_cyc != 5) begin errors++; $display("FAIL b2b_second result=%0d done=%0d exp 7 5", m_result, m_done_cyc); end
        checks++; if (m_run_cyc != 1) begin errors++; $display("FAIL b2b_second_run got=%0d exp=1", m_run_cyc); end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        run_op(8, 40, 4);
        checks++; if (m_done_cnt != 1 || m_done_cyc != 12) begin errors++; $display("FAIL ign_done cnt=%0d cyc=%0d exp 1 12", m_done_cnt, m_done_cyc); end
        checks++; if (m_result !== 16'd36) begin errors++; $display("FAIL ign_result got=%0d exp=36", m_result); end
        checks++; if (m_run_cnt != 1 || m_ce_cnt != 8) begin errors++; $display("FAIL ign_run run=%0d ce=%0d exp 1 8", m_run_cnt, m_ce_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (idle_o !== 1'b1 || running_o !== 1'b0) begin errors++; $display("FAIL ign_stays_idle idle=%b running=%b exp 1 0", idle_o, running_o); end
    endtask

    task automatic test_reset_mid_run();
        int dn;
        for (int i = 0; i < 16; i++) mem[i] = 8'd1;
        num_cnt_i = 9'd16;
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (idle_o !== 1'b1 || running_o !== 1'b0) begin errors++; $display("FAIL mid_state idle=%b running=%b exp 1 0", idle_o, running_o); end
        checks++; if (bus.ce_o !== 1'b0 || bus.addr_o !== 8'd0 || bus.valid_o !== 1'b0 || bus.run_o !== 1'b0) begin
            errors++; $display("FAIL mid_bus ce=%b addr=%0d valid=%b run=%b exp all 0", bus.ce_o, bus.addr_o, bus.valid_o, bus.run_o);
        end
        checks++; if (result_o !== 16'd0 || done_o !== 1'b0) begin errors++; $display("FAIL mid_result result=%0d done=%b exp 0 0", result_o, done_o); end
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", dn); end
        mem[0] = 8'd9; mem[1] = 8'd10; mem[2] = 8'd11;
        run_op(3, 30, -1);
        checks++; if (m_result !== 16'd30 || m_done_cyc != 7) begin errors++; $display("FAIL mid_after result=%0d done=%0d exp 30 7", m_result, m_done_cyc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        test_reset();
        test_n4();
        test_n256();
        test_n0();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
